// File: rtl/reg_file_mp.sv
// Multi-port register file with same-cycle write bypass, a pending-producer
// scoreboard and a sequenced full-file clear.
module reg_file_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_pend,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_addr,
    input  logic                clr_req,
    output logic                clr_busy,
    output logic                clr_done
);

    localparam bit HasZero = (ZERO_REG != 0);

    typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   mem_q [DEPTH];
    logic [XLEN-1:0]   mem_d [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic              wr_ok, sb_ok;

    assign wr_ok = wr_en && (state_q != StClear) && !(HasZero && (wr_addr == '0));
    assign sb_ok = sb_set && (state_q != StClear) && !(HasZero && (sb_addr == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pend_q  <= '0;
            mem_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            mem_q   <= mem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (clr_req) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        clr_busy = (state_q == StClear);
        clr_done = (state_q == StDone);
    end

    always_comb begin
        mem_d = mem_q;
        if (state_q == StClear) begin
            mem_d[cnt_q] = '0;
        end else if (wr_ok) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Set is applied after clear so a same-cycle set on the written entry wins.
    always_comb begin
        pend_d = pend_q;
        if ((state_q == StIdle) && clr_req) begin
            pend_d = '0;
        end else begin
            if (wr_ok) pend_d[wr_addr] = 1'b0;
            if (sb_ok) pend_d[sb_addr] = 1'b1;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] addr;
        logic          mask, wr_hit, sb_hit;

        assign addr   = rd_addr[k*AW +: AW];
        assign mask   = clr_busy || (HasZero && (addr == '0));
        assign wr_hit = wr_en && (wr_addr == addr);
        assign sb_hit = sb_set && (sb_addr == addr);

        assign rd_data[k*XLEN +: XLEN] = mask ? '0 : (wr_hit ? wr_data : mem_q[addr]);
        assign rd_pend[k] = !mask && !(wr_hit && !sb_hit) && pend_q[addr];
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: a default instance and a wide, shallow,
// four-port instance without a zero register.
module tb_reg_file_mp;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [9:0]   rd_addr_a;
    logic [63:0]  rd_data_a;
    logic [1:0]   rd_pend_a;
    logic         wr_en_a, sb_set_a, clr_req_a, clr_busy_a, clr_done_a;
    logic [4:0]   wr_addr_a, sb_addr_a;
    logic [31:0]  wr_data_a;

    logic [15:0]  rd_addr_b;
    logic [255:0] rd_data_b;
    logic [3:0]   rd_pend_b;
    logic         wr_en_b, sb_set_b, clr_req_b, clr_busy_b, clr_done_b;
    logic [3:0]   wr_addr_b, sb_addr_b;
    logic [63:0]  wr_data_b;

    reg_file_mp u_dut_a (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_pend(rd_pend_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .sb_set(sb_set_a), .sb_addr(sb_addr_a),
        .clr_req(clr_req_a), .clr_busy(clr_busy_a), .clr_done(clr_done_a)
    );

    reg_file_mp #(.XLEN(64), .DEPTH(16), .NRD(4), .ZERO_REG(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_pend(rd_pend_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .sb_set(sb_set_b), .sb_addr(sb_addr_b),
        .clr_req(clr_req_b), .clr_busy(clr_busy_b), .clr_done(clr_done_b)
    );

    // kind: 0 rd_data, 1 rd_pend, 2 clr_busy, 3 clr_done
    typedef struct {
        logic [127:0] name;
        int           kind;
        int           sel;
        int           port;
        logic [63:0]  val;
        logic [63:0]  got;
        bit           smp;
    } exp_t;

    exp_t        sbq[$];
    int          errors = 0;
    int          checks = 0;
    logic [63:0] mdl [2][32];
    bit          pmdl [2][32];

    function automatic int depth_of(input int sel);
        return (sel != 0) ? 16 : 32;
    endfunction

    function automatic int nrd_of(input int sel);
        return (sel != 0) ? 4 : 2;
    endfunction

    function automatic logic [63:0] trunc(input int sel, input logic [63:0] v);
        return (sel != 0) ? v : {32'h0, v[31:0]};
    endfunction

    function automatic logic [63:0] observe(input int kind, input int sel, input int port);
        case (kind)
            0:       return (sel != 0) ? rd_data_b[port*64 +: 64] : {32'h0, rd_data_a[port*32 +: 32]};
            1:       return {63'h0, (sel != 0) ? rd_pend_b[port] : rd_pend_a[port]};
            2:       return {63'h0, (sel != 0) ? clr_busy_b : clr_busy_a};
            default: return {63'h0, (sel != 0) ? clr_done_b : clr_done_a};
        endcase
    endfunction

    task automatic push(input logic [127:0] name, input int kind, input int sel, input int port,
                        input logic [63:0] val);
        exp_t e;
        e.name = name; e.kind = kind; e.sel = sel; e.port = port;
        e.val = val; e.got = 'x; e.smp = 1'b0;
        sbq.push_back(e);
    endtask

    task automatic sample();
        for (int i = 0; i < sbq.size(); i++) begin
            if (!sbq[i].smp) begin
                sbq[i].got = observe(sbq[i].kind, sbq[i].sel, sbq[i].port);
                sbq[i].smp = 1'b1;
            end
        end
    endtask

    task automatic set_rd(input int sel, input int port, input int addr);
        if (sel != 0) rd_addr_b[port*4 +: 4] = 4'(addr);
        else          rd_addr_a[port*5 +: 5] = 5'(addr);
    endtask

    task automatic set_wr(input int sel, input logic en, input int addr, input logic [63:0] data);
        if (sel != 0) begin wr_en_b = en; wr_addr_b = 4'(addr); wr_data_b = data; end
        else          begin wr_en_a = en; wr_addr_a = 5'(addr); wr_data_a = data[31:0]; end
    endtask

    task automatic set_sb(input int sel, input logic en, input int addr);
        if (sel != 0) begin sb_set_b = en; sb_addr_b = 4'(addr); end
        else          begin sb_set_a = en; sb_addr_a = 5'(addr); end
    endtask

    task automatic model_zero();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 32; i++) begin mdl[s][i] = '0; pmdl[s][i] = 1'b0; end
    endtask

    // One clock edge with both files outside CLEAR; the model follows the driven inputs.
    task automatic tick();
        if (wr_en_a && wr_addr_a != 5'd0) begin
            mdl[0][wr_addr_a] = {32'h0, wr_data_a}; pmdl[0][wr_addr_a] = 1'b0;
        end
        if (sb_set_a && sb_addr_a != 5'd0) pmdl[0][sb_addr_a] = 1'b1;
        if (wr_en_b) begin mdl[1][wr_addr_b] = wr_data_b; pmdl[1][wr_addr_b] = 1'b0; end
        if (sb_set_b) pmdl[1][sb_addr_b] = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        rd_addr_a = 10'h0; wr_en_a = 0; wr_addr_a = 0; wr_data_a = 0;
        sb_set_a = 0; sb_addr_a = 0; clr_req_a = 0;
        rd_addr_b = 16'h0; wr_en_b = 0; wr_addr_b = 0; wr_data_b = 0;
        sb_set_b = 0; sb_addr_b = 0; clr_req_b = 0;
        model_zero();
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            for (int p = 0; p < nrd_of(s); p++) set_rd(s, p, p + 3);
        end
        #1;
        for (int s = 0; s < 2; s++) begin
            for (int p = 0; p < nrd_of(s); p++) begin
                push("rst_data", 0, s, p, 64'h0);
                push("rst_pend", 1, s, p, 64'h0);
            end
            push("rst_busy", 2, s, 0, 64'h0);
            push("rst_done", 3, s, 0, 64'h0);
        end
        sample();
        @(negedge clk);
        rst = 1'b0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (e.got !== e.val) begin
                errors++;
                $display("FAIL %0s: dut%0d port%0d got %h expected %h", e.name, e.sel, e.port, e.got, e.val);
            end
        end
    endtask

    task automatic test_bypass(input int sel);
        exp_t        e;
        logic [63:0] v;
        v = (sel != 0) ? 64'hDEAD_BEEF_0BAD_F00D : 64'h0000_0000_DEAD_BEEF;
        for (int p = 0; p < nrd_of(sel); p++) set_rd(sel, p, 5 + p);
        for (int p = 0; p < nrd_of(sel); p++) begin
            set_wr(sel, 1'b1, 5 + p, v ^ 64'(p));
            #1;
            for (int q = 0; q < nrd_of(sel); q++)
                push("byp_same", 0, sel, q, (q == p) ? trunc(sel, v ^ 64'(p)) : mdl[sel][5 + q]);
            sample();
            tick();
        end
        set_wr(sel, 1'b0, 0, 64'h0);
        #1;
        for (int q = 0; q < nrd_of(sel); q++)
            push("byp_after", 0, sel, q, trunc(sel, v ^ 64'(q)));
        sample();
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (e.got !== e.val) begin
                errors++;
                $display("FAIL %0s: dut%0d port%0d got %h expected %h", e.name, e.sel, e.port, e.got, e.val);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_zero(input int sel);
        exp_t        e;
        logic [63:0] want;
        want = (sel != 0) ? 64'h1234_5678 : 64'h0;
        for (int p = 0; p < nrd_of(sel); p++) set_rd(sel, p, 0);
        set_wr(sel, 1'b1, 0, 64'h1234_5678);
        #1;
        for (int p = 0; p < nrd_of(sel); p++) begin
            push("zero_byp", 0, sel, p, want);
            push("zero_pend", 1, sel, p, 64'h0);
        end
        sample();
        tick();
        set_wr(sel, 1'b0, 0, 64'h0);
        #1;
        for (int p = 0; p < nrd_of(sel); p++) push("zero_rd", 0, sel, p, want);
        sample();
        set_sb(sel, 1'b1, 0);
        tick();
        set_sb(sel, 1'b0, 0);
        #1;
        for (int p = 0; p < nrd_of(sel); p++)
            push("zero_sb", 1, sel, p, (sel != 0) ? 64'h1 : 64'h0);
        sample();
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (e.got !== e.val) begin
                errors++;
                $display("FAIL %0s: dut%0d port%0d got %h expected %h", e.name, e.sel, e.port, e.got, e.val);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_scoreboard(input int sel);
        exp_t e;
        set_rd(sel, 0, 7);
        set_rd(sel, 1, 8);
        set_sb(sel, 1'b1, 7);
        #1;
        push("sb_pre", 1, sel, 0, 64'h0);
        sample();
        tick();
        set_sb(sel, 1'b0, 0);
        #1;
        push("sb_set", 1, sel, 0, 64'h1);
        push("sb_other", 1, sel, 1, 64'h0);
        sample();
        set_sb(sel, 1'b1, 7);
        set_wr(sel, 1'b1, 7, 64'h5555);
        #1;
        push("sb_wr_pend", 1, sel, 0, 64'h1);
        push("sb_wr_byp", 0, sel, 0, 64'h5555);
        sample();
        tick();
        set_sb(sel, 1'b0, 0);
        set_wr(sel, 1'b0, 0, 64'h0);
        #1;
        push("sb_wins", 1, sel, 0, 64'h1);
        push("sb_wr_data", 0, sel, 0, 64'h5555);
        sample();
        set_wr(sel, 1'b1, 7, 64'h6666);
        #1;
        push("wr_clr_now", 1, sel, 0, 64'h0);
        sample();
        tick();
        set_wr(sel, 1'b0, 0, 64'h0);
        #1;
        push("wr_clr", 1, sel, 0, 64'h0);
        push("wr_data", 0, sel, 0, 64'h6666);
        sample();
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (e.got !== e.val) begin
                errors++;
                $display("FAIL %0s: dut%0d port%0d got %h expected %h", e.name, e.sel, e.port, e.got, e.val);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_clear(input int sel);
        exp_t        e;
        int          busy_n, done_n, done_at;
        logic [63:0] w2;
        w2 = 64'h2222_0000_0000_2222;
        for (int i = 0; i < depth_of(sel); i++) begin
            set_wr(sel, 1'b1, i, (sel != 0) ? {32'hA5A5_0000 | 32'(i), 32'h5A5A_0000 | 32'(i)}
                                            : {32'h0, 32'hC0DE_0000 | 32'(i)});
            tick();
        end
        set_wr(sel, 1'b0, 0, 64'h0);
        set_sb(sel, 1'b1, 9);
        tick();
        set_sb(sel, 1'b0, 0);
        set_rd(sel, 0, 9);
        #1;
        push("pre_clr_data", 0, sel, 0, mdl[sel][9]);
        push("pre_clr_pend", 1, sel, 0, 64'h1);
        sample();
        @(negedge clk);
        if (sel != 0) clr_req_b = 1'b1; else clr_req_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr_req_a = 1'b0;
        clr_req_b = 1'b0;
        busy_n = 0; done_n = 0; done_at = -1;
        for (int c = 0; c < depth_of(sel) + 6; c++) begin
            if (c == 0) begin
                set_wr(sel, 1'b1, 3, 64'hBAD0_BAD0_BAD0_BAD0);
                set_sb(sel, 1'b1, 4);
            end else begin
                set_wr(sel, 1'b0, 0, 64'h0);
                set_sb(sel, 1'b0, 0);
            end
            #1;
            if (c == 0) begin
                push("clr_busy1", 2, sel, 0, 64'h1);
                push("clr_done1", 3, sel, 0, 64'h0);
                push("clr_rd_zero", 0, sel, 0, 64'h0);
                push("clr_pend_zero", 1, sel, 0, 64'h0);
                sample();
            end
            if (observe(2, sel, 0) == 64'h1) busy_n++;
            if (observe(3, sel, 0) == 64'h1) begin
                done_n++;
                done_at = c;
                set_wr(sel, 1'b1, 2, w2);
            end
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (busy_n !== depth_of(sel)) begin
            errors++;
            $display("FAIL clr_busy_len: dut%0d got %0d cycles expected %0d", sel, busy_n, depth_of(sel));
        end
        checks++;
        if (done_n !== 1) begin
            errors++;
            $display("FAIL clr_done_len: dut%0d got %0d cycles expected 1", sel, done_n);
        end
        checks++;
        if (done_at !== depth_of(sel)) begin
            errors++;
            $display("FAIL clr_done_pos: dut%0d got cycle %0d expected %0d", sel, done_at, depth_of(sel));
        end
        for (int i = 0; i < 32; i++) begin mdl[sel][i] = '0; pmdl[sel][i] = 1'b0; end
        mdl[sel][2] = trunc(sel, w2);
        for (int i = 0; i < depth_of(sel); i += nrd_of(sel)) begin
            for (int p = 0; p < nrd_of(sel); p++) set_rd(sel, p, i + p);
            #1;
            for (int p = 0; p < nrd_of(sel); p++) begin
                push("clr_entry", 0, sel, p, mdl[sel][i + p]);
                push("clr_pend", 1, sel, p, 64'h0);
            end
            sample();
            @(negedge clk);
        end
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (e.got !== e.val) begin
                errors++;
                $display("FAIL %0s: dut%0d port%0d got %h expected %h", e.name, e.sel, e.port, e.got, e.val);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        exp_t e;
        int   done_n;
        set_wr(0, 1'b1, 9, 64'h99);
        tick();
        set_wr(0, 1'b0, 0, 64'h0);
        clr_req_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr_req_a = 1'b0;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk);
            @(negedge clk);
        end
        set_rd(0, 0, 9);
        set_rd(0, 1, 12);
        #1;
        push("c10_busy", 2, 0, 0, 64'h1);
        sample();
        rst = 1'b1;
        #1;
        push("rst_mid_busy", 2, 0, 0, 64'h0);
        push("rst_mid_done", 3, 0, 0, 64'h0);
        push("rst_mid_rd9", 0, 0, 0, 64'h0);
        push("rst_mid_rd12", 0, 0, 1, 64'h0);
        sample();
        model_zero();
        done_n = 0;
        @(posedge clk);
        @(negedge clk);
        if (clr_done_a) done_n++;
        rst = 1'b0;
        set_wr(0, 1'b1, 12, 64'hABCD);
        tick();
        set_wr(0, 1'b0, 0, 64'h0);
        #1;
        push("post_rst_wr", 0, 0, 1, 64'hABCD);
        push("post_rst_rd9", 0, 0, 0, 64'h0);
        push("post_rst_busy", 2, 0, 0, 64'h0);
        sample();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (clr_done_a) done_n++;
        end
        checks++;
        if (done_n !== 0) begin
            errors++;
            $display("FAIL rst_no_done: got %0d done pulses expected 0", done_n);
        end
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (e.got !== e.val) begin
                errors++;
                $display("FAIL %0s: dut%0d port%0d got %h expected %h", e.name, e.sel, e.port, e.got, e.val);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_bypass(0);
        test_zero(0);
        test_scoreboard(0);
        test_clear(0);
        test_reset_mid_clear();
        test_bypass(1);
        test_zero(1);
        test_scoreboard(1);
        test_clear(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not reach the summary within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width in bits.
REQ-002 SHALL have parameter DEPTH, default 32: register count; a power of two, at least 2; AW = log2(DEPTH).
REQ-003 SHALL have parameter NRD, default 2: number of read ports, 1..4.
REQ-004 SHALL have parameter ZERO_REG, default 1: when 1, entry 0 is hardwired to zero.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous reset, active-high.
REQ-007 SHALL have port rd_addr, input, NRD*AW: read addresses; port k occupies bits [k*AW +: AW].
REQ-008 SHALL have port rd_data, output, NRD*XLEN: read data; port k occupies bits [k*XLEN +: XLEN].
REQ-009 SHALL have port rd_pend, output, NRD: port k's addressed entry has a pending (unwritten) producer.
REQ-010 SHALL have port wr_en, input, 1: write strobe.
REQ-011 SHALL have port wr_addr, input, AW: write address.
REQ-012 SHALL have port wr_data, input, XLEN: write data.
REQ-013 SHALL have port sb_set, input, 1: mark entry sb_addr as pending.
REQ-014 SHALL have port sb_addr, input, AW: scoreboard set address.
REQ-015 SHALL have port clr_req, input, 1: request a full-file clear.
REQ-016 SHALL have port clr_busy, output, 1: clear sequence in progress.
REQ-017 SHALL have port clr_done, output, 1: one-cycle pulse when the clear completes.

Function
REQ-018 SHALL perform reads combinationally: rd_data[k] = entry[rd_addr[k]] in the same cycle.
REQ-019 SHALL bypass writes to reads: when wr_en=1 and wr_addr==rd_addr[k], rd_data[k]=wr_data in that cycle.
REQ-020 SHALL, with ZERO_REG=1, always read entry 0 as 0, never bypass to it, ignore writes to it, and hold rd_pend=0 for it.
REQ-021 SHALL write entry[wr_addr]<=wr_data on the rising edge when wr_en=1 and the FSM is IDLE.
REQ-022 SHALL keep a DEPTH-bit pending vector: sb_set=1 sets pend[sb_addr]; an accepted write clears pend[wr_addr].
REQ-023 SHALL, when sb_set and a write target the same address in one cycle, leave pend set: set wins.
REQ-024 SHALL drive rd_pend[k]=pend[rd_addr[k]], except 0 when a same-cycle write matches rd_addr[k] and sb_set does not target that address.
REQ-025 SHALL implement a clear FSM with states IDLE, CLEAR and DONE, and an AW-bit counter cnt.
REQ-026 SHALL, in IDLE with clr_req=1, go to CLEAR with cnt=0 and clear the entire pend vector on that edge.
REQ-027 SHALL, in CLEAR, zero entry[cnt] each cycle, increment cnt, and go to DONE after the cycle in which cnt==DEPTH-1; CLEAR therefore lasts exactly DEPTH cycles.
REQ-028 SHALL stay in DONE for one cycle, then return to IDLE.
REQ-029 SHALL drive clr_busy=1 exactly while in CLEAR, and clr_done=1 exactly while in DONE.
REQ-030 SHALL, while in CLEAR, ignore wr_en and sb_set, and drive every rd_data to 0 and every rd_pend to 0.
REQ-031 SHALL ignore clr_req in CLEAR and in DONE; a new clear needs clr_req=1 in IDLE.
REQ-032 SHALL accept writes and sb_set normally in DONE; reads in DONE follow REQ-018 and REQ-019.

Reset
REQ-033 SHALL, while rst=1 and regardless of clk, drive all entries to 0, pend to 0, the FSM to IDLE, cnt to 0, and clr_busy and clr_done to 0.
REQ-034 SHALL, if rst asserts during CLEAR, abort the sequence immediately with no clr_done pulse.
REQ-035 SHALL resume normal operation on the first rising clk edge after rst deasserts.

Verification
REQ-036 SHALL verify write then bypass: write 0xDEADBEEF to x5 with rd_addr[0]=5 -> rd_data[0]=0xDEADBEEF in the same cycle and after the edge.
REQ-037 SHALL verify the zero register: write 0x12345678 to x0, then read x0 on all ports -> 0, with rd_pend=0.
REQ-038 SHALL verify the scoreboard: sb_set x7, then read x7 -> rd_pend=1; next, sb_set x7 plus a write of x7 in one cycle -> pend stays 1; a write of x7 alone -> rd_pend=0.
REQ-039 SHALL verify the clear: fill all entries, pulse clr_req -> clr_busy high for exactly DEPTH cycles, then clr_done for one cycle; all entries then read 0; a write during CLEAR is discarded.
REQ-040 SHALL verify reset mid-clear: assert rst at CLEAR cycle 10 -> clr_busy=0 at once, clr_done never pulses, all entries read 0, and a write is accepted on the next edge after rst deasserts.
REQ-041 SHALL verify parameters: repeat REQ-036 to REQ-039 with XLEN=64, DEPTH=16, NRD=4, ZERO_REG=0 -> x0 is writable, all 4 ports bypass independently, and CLEAR lasts 16 cycles.
